// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, tag helpers and entry layout for the reorder buffer.
// Tags run 1..ROB_SZ; tag 0 means "no producer".
package reorder_buffer_pkg;

    localparam int ROB_SZ_LOG = 4;
    localparam int ROB_SZ     = 1 << ROB_SZ_LOG;
    localparam int TAG_W      = ROB_SZ_LOG + 1;

    localparam logic [TAG_W-1:0] TAG_NONE  = {TAG_W{1'b0}};
    localparam logic [TAG_W-1:0] TAG_FIRST = {{(TAG_W-1){1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] TAG_LAST  = TAG_W'(ROB_SZ);

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        rd_hv;
        logic [4:0]  rd;
        logic        is_br;
        logic        pred_jump;
        logic        act_jump;
        logic [31:0] value;
        logic [31:0] pc;
    } rob_entry_t;

    function automatic logic tag_valid(input logic [TAG_W-1:0] tag);
        return (tag != TAG_NONE) && (tag <= TAG_LAST);
    endfunction

    function automatic logic [ROB_SZ_LOG-1:0] tag_idx(input logic [TAG_W-1:0] tag);
        return ROB_SZ_LOG'(tag - TAG_FIRST);
    endfunction

    function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] tag);
        return (tag == TAG_LAST) ? TAG_FIRST : (tag + TAG_FIRST);
    endfunction

endpackage

// File: rtl/reorder_buffer_lookup_port.sv
// Tag -> ready/value lookup for one register-file source operand.
// Build option ROB_CDB_BYPASS_EN forwards a same-cycle CDB result.
module rob_lookup_port
    import reorder_buffer_pkg::*;
(
    input  logic [TAG_W-1:0]    rs_id,
    input  logic [ROB_SZ-1:0]   busy_vec,
    input  logic [ROB_SZ-1:0]   ready_vec,
    input  logic [ROB_SZ*32-1:0] value_vec,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [31:0]         cdb_value,
    output logic                rs_ready,
    output logic [31:0]         rs_value
);

    logic [ROB_SZ_LOG-1:0] idx_s;
    logic                  hit_s;

`ifndef ROB_CDB_BYPASS_EN
    logic bypass_unused_s;
    assign bypass_unused_s = ^{cdb_valid, cdb_tag, cdb_value};
`endif

    // Resolve the looked-up tag against registered entry state (and the CDB when bypassing).
    always_comb begin
        idx_s    = tag_idx(rs_id);
        hit_s    = tag_valid(rs_id) && busy_vec[idx_s];
        rs_ready = 1'b0;
        rs_value = 32'd0;
        if (hit_s && ready_vec[idx_s]) begin
            rs_ready = 1'b1;
            rs_value = value_vec[idx_s*32 +: 32];
        end else begin
            rs_ready = 1'b0;
        end
`ifdef ROB_CDB_BYPASS_EN
        if (hit_s && cdb_valid && (cdb_tag == rs_id)) begin
            rs_ready = 1'b1;
            rs_value = cdb_value;
        end else begin
            rs_value = rs_value;
        end
`endif
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture, operand lookup and retire.
// Optional build macro ROB_CDB_BYPASS_EN enables same-cycle CDB forwarding on lookups.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             run_add,
    input  logic             rd_hv,
    input  logic [4:0]       rd,
    input  logic             is_br,
    input  logic             pred_jump,
    output logic [TAG_W-1:0] tail,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_jump,
    input  logic [31:0]      cdb_pc,
    input  logic [TAG_W-1:0] rs1_id,
    input  logic [TAG_W-1:0] rs2_id,
    output logic             rob_rs1_ready,
    output logic [31:0]      rob_rs1_value,
    output logic             rob_rs2_ready,
    output logic [31:0]      rob_rs2_value,
    output logic             run_upd,
    output logic [4:0]       commit_rd,
    output logic [31:0]      res,
    output logic [TAG_W-1:0] head,
    output logic             reset,
    output logic [31:0]      redirect_pc
);

    rob_entry_t            entry_r [ROB_SZ];
    logic [TAG_W-1:0]      head_r;
    logic [TAG_W-1:0]      tail_r;
    logic [TAG_W-1:0]      count_r;
    logic                  reset_r;
    logic [31:0]           redirect_pc_r;

    rob_entry_t            head_ent_s;
    rob_entry_t            new_ent_s;
    logic [ROB_SZ_LOG-1:0] head_idx_s;
    logic [ROB_SZ_LOG-1:0] tail_idx_s;
    logic [ROB_SZ_LOG-1:0] cdb_idx_s;
    logic                  full_s;
    logic                  retire_s;
    logic                  mispred_s;
    logic                  issue_s;
    logic                  cdb_wr_s;
    logic [ROB_SZ-1:0]     busy_vec_s;
    logic [ROB_SZ-1:0]     ready_vec_s;
    logic [ROB_SZ*32-1:0]  value_vec_s;

    // Retire, issue and CDB-capture qualification for this cycle.
    always_comb begin
        head_idx_s = tag_idx(head_r);
        tail_idx_s = tag_idx(tail_r);
        cdb_idx_s  = tag_idx(cdb_tag);
        head_ent_s = entry_r[head_idx_s];
        full_s     = (count_r == TAG_LAST);
        retire_s   = head_ent_s.busy && head_ent_s.ready && rdy && !reset_r;
        mispred_s  = retire_s && head_ent_s.is_br && (head_ent_s.act_jump != head_ent_s.pred_jump);
        issue_s    = run_add && !full_s && !reset_r && rdy && !mispred_s;
        if (cdb_valid && tag_valid(cdb_tag)) begin
            cdb_wr_s = entry_r[cdb_idx_s].busy && !reset_r && rdy;
        end else begin
            cdb_wr_s = 1'b0;
        end
        new_ent_s = '{busy: 1'b1, ready: 1'b0, rd_hv: rd_hv, rd: rd, is_br: is_br,
                      pred_jump: pred_jump, act_jump: 1'b0, value: 32'd0, pc: 32'd0};
    end

    // Flatten entry state for the lookup ports.
    always_comb begin
        busy_vec_s  = {ROB_SZ{1'b0}};
        ready_vec_s = {ROB_SZ{1'b0}};
        value_vec_s = {(ROB_SZ*32){1'b0}};
        for (int i = 0; i < ROB_SZ; i++) begin
            busy_vec_s[i]         = entry_r[i].busy;
            ready_vec_s[i]        = entry_r[i].ready;
            value_vec_s[i*32 +: 32] = entry_r[i].value;
        end
    end

    // Entry storage, pointers and occupancy; a mispredicted retire flushes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                entry_r[i] <= '0;
            end
            head_r  <= TAG_FIRST;
            tail_r  <= TAG_FIRST;
            count_r <= TAG_NONE;
        end else if (mispred_s) begin
            for (int i = 0; i < ROB_SZ; i++) begin
                entry_r[i] <= '0;
            end
            head_r  <= TAG_FIRST;
            tail_r  <= TAG_FIRST;
            count_r <= TAG_NONE;
        end else begin
            if (cdb_wr_s) begin
                entry_r[cdb_idx_s].ready    <= 1'b1;
                entry_r[cdb_idx_s].value    <= cdb_value;
                entry_r[cdb_idx_s].act_jump <= cdb_jump;
                entry_r[cdb_idx_s].pc       <= cdb_pc;
            end
            if (issue_s) begin
                entry_r[tail_idx_s] <= new_ent_s;
                tail_r              <= tag_next(tail_r);
            end
            if (retire_s) begin
                entry_r[head_idx_s].busy  <= 1'b0;
                entry_r[head_idx_s].ready <= 1'b0;
                head_r                    <= tag_next(head_r);
            end
            case ({issue_s, retire_s})
                2'b10:   count_r <= count_r + TAG_FIRST;
                2'b01:   count_r <= count_r - TAG_FIRST;
                default: count_r <= count_r;
            endcase
        end
    end

    // One-cycle flush pulse and its redirect target, both frozen while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reset_r       <= 1'b0;
            redirect_pc_r <= 32'd0;
        end else if (rdy) begin
            reset_r       <= mispred_s;
            redirect_pc_r <= mispred_s ? head_ent_s.pc : redirect_pc_r;
        end else begin
            reset_r       <= reset_r;
            redirect_pc_r <= redirect_pc_r;
        end
    end

    rob_lookup_port u_rs1 (
        .rs_id     (rs1_id),
        .busy_vec  (busy_vec_s),
        .ready_vec (ready_vec_s),
        .value_vec (value_vec_s),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .rs_ready  (rob_rs1_ready),
        .rs_value  (rob_rs1_value)
    );

    rob_lookup_port u_rs2 (
        .rs_id     (rs2_id),
        .busy_vec  (busy_vec_s),
        .ready_vec (ready_vec_s),
        .value_vec (value_vec_s),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .rs_ready  (rob_rs2_ready),
        .rs_value  (rob_rs2_value)
    );

    assign tail        = tail_r;
    assign full        = full_s;
    assign run_upd     = retire_s;
    assign commit_rd   = (retire_s && head_ent_s.rd_hv) ? head_ent_s.rd : 5'd0;
    assign res         = retire_s ? head_ent_s.value : 32'd0;
    assign head        = head_r;
    assign reset       = reset_r;
    assign redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer; expectations are hand-computed.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, run_add, rd_hv, is_br, pred_jump;
    logic [4:0]  rd;
    logic [4:0]  tail, head, cdb_tag, rs1_id, rs2_id;
    logic        full, cdb_valid, cdb_jump;
    logic [31:0] cdb_value, cdb_pc;
    logic        rob_rs1_ready, rob_rs2_ready, run_upd, reset;
    logic [31:0] rob_rs1_value, rob_rs2_value, res, redirect_pc;
    logic [4:0]  commit_rd;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .run_add(run_add), .rd_hv(rd_hv), .rd(rd),
        .is_br(is_br), .pred_jump(pred_jump), .tail(tail), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_jump(cdb_jump), .cdb_pc(cdb_pc), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rob_rs1_ready(rob_rs1_ready), .rob_rs1_value(rob_rs1_value),
        .rob_rs2_ready(rob_rs2_ready), .rob_rs2_value(rob_rs2_value),
        .run_upd(run_upd), .commit_rd(commit_rd), .res(res), .head(head),
        .reset(reset), .redirect_pc(redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; run_add = 1'b0; rd_hv = 1'b0; rd = 5'd0; is_br = 1'b0; pred_jump = 1'b0;
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0; cdb_jump = 1'b0; cdb_pc = 32'd0;
        rs1_id = 5'd0; rs2_id = 5'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input logic [4:0] r, input logic br, input logic pj);
        run_add = 1'b1; rd = r; rd_hv = (r != 5'd0); is_br = br; pred_jump = pj;
        step();
        run_add = 1'b0; rd = 5'd0; rd_hv = 1'b0; is_br = 1'b0; pred_jump = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v, input logic j, input logic [31:0] pc);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_jump = j; cdb_pc = pc;
        step();
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0; cdb_jump = 1'b0; cdb_pc = 32'd0;
    endtask

    initial begin
        // Reset state
        idle();
        rst = 1'b1;
        #2;
        check("rst_tail", tail, 32'd1);
        check("rst_head", head, 32'd1);
        check("rst_full", full, 32'd0);
        check("rst_run_upd", run_upd, 32'd0);
        check("rst_reset", reset, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_commit_rd", commit_rd, 32'd0);
        step();
        rst = 1'b0;
        #1;

        // 1: issue rd=5, CDB 0x2A, retire
        issue(5'd5, 1'b0, 1'b0);
        check("t1_tail", tail, 32'd2);
        rs1_id = 5'd1;
        #1;
        check("t1_rs1_ready_busy", rob_rs1_ready, 32'd0);
        check("t1_rs1_value_busy", rob_rs1_value, 32'd0);
        cdb(5'd1, 32'h2A, 1'b0, 32'd0);
        check("t1_run_upd", run_upd, 32'd1);
        check("t1_commit_rd", commit_rd, 32'd5);
        check("t1_res", res, 32'h2A);
        check("t1_head", head, 32'd1);
        check("t1_rs1_ready", rob_rs1_ready, 32'd1);
        check("t1_rs1_value", rob_rs1_value, 32'h2A);
        step();
        check("t1_post_run_upd", run_upd, 32'd0);
        check("t1_post_head", head, 32'd2);

        // 2: fill, ignored 17th issue, retire does not unblock same cycle, wrap
        do_reset();
        for (int i = 0; i < 16; i++) issue(5'd1, 1'b0, 1'b0);
        check("t2_full", full, 32'd1);
        check("t2_tail_wrap", tail, 32'd1);
        issue(5'd2, 1'b0, 1'b0);
        check("t2_17th_tail", tail, 32'd1);
        check("t2_17th_full", full, 32'd1);
        cdb(5'd1, 32'h55, 1'b0, 32'd0);
        check("t2_retire", run_upd, 32'd1);
        check("t2_full_during_retire", full, 32'd1);
        run_add = 1'b1; rd = 5'd3; rd_hv = 1'b1;
        step();
        run_add = 1'b0;
        check("t2_full_drop", full, 32'd0);
        check("t2_tail_blocked", tail, 32'd1);
        check("t2_head", head, 32'd2);
        issue(5'd4, 1'b0, 1'b0);
        check("t2_tail_after", tail, 32'd2);
        check("t2_full_again", full, 32'd1);

        // 3: out-of-order completion, in-order retire
        do_reset();
        issue(5'd1, 1'b0, 1'b0);
        issue(5'd2, 1'b0, 1'b0);
        issue(5'd3, 1'b0, 1'b0);
        cdb(5'd3, 32'h33, 1'b0, 32'd0);
        check("t3_no_retire_a", run_upd, 32'd0);
        cdb(5'd2, 32'h22, 1'b0, 32'd0);
        check("t3_no_retire_b", run_upd, 32'd0);
        cdb(5'd1, 32'h11, 1'b0, 32'd0);
        check("t3_r1_head", head, 32'd1);
        check("t3_r1_res", res, 32'h11);
        step();
        check("t3_r2_head", head, 32'd2);
        check("t3_r2_res", res, 32'h22);
        check("t3_r2_rd", commit_rd, 32'd2);
        step();
        check("t3_r3_head", head, 32'd3);
        check("t3_r3_res", res, 32'h33);
        check("t3_r3_upd", run_upd, 32'd1);
        step();
        check("t3_drained", run_upd, 32'd0);

        // 4: branch mispredict flush
        do_reset();
        issue(5'd1, 1'b1, 1'b0);
        issue(5'd2, 1'b0, 1'b0);
        issue(5'd3, 1'b0, 1'b0);
        cdb(5'd1, 32'h44, 1'b1, 32'h100);
        check("t4_br_retire", run_upd, 32'd1);
        check("t4_br_rd", commit_rd, 32'd1);
        check("t4_no_flush_yet", reset, 32'd0);
        run_add = 1'b1; rd = 5'd9; rd_hv = 1'b1;
        step();
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'h77;
        #1;
        check("t4_reset", reset, 32'd1);
        check("t4_redirect", redirect_pc, 32'h100);
        check("t4_tail", tail, 32'd1);
        check("t4_full", full, 32'd0);
        check("t4_upd_in_flush", run_upd, 32'd0);
        step();
        run_add = 1'b0; cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0;
        check("t4_reset_pulse", reset, 32'd0);
        check("t4_tail_held", tail, 32'd1);
        check("t4_head", head, 32'd1);
        issue(5'd6, 1'b0, 1'b0);
        check("t4_issue_after", tail, 32'd2);
        rs1_id = 5'd1;
        #1;
        check("t4_no_stale_ready", rob_rs1_ready, 32'd0);

        // 5: lookup in the same cycle as CDB
        do_reset();
        issue(5'd1, 1'b0, 1'b0);
        issue(5'd2, 1'b0, 1'b0);
        rs2_id = 5'd2;
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'd7;
        #1;
`ifdef ROB_CDB_BYPASS_EN
        check("t5_bypass_ready", rob_rs2_ready, 32'd1);
        check("t5_bypass_value", rob_rs2_value, 32'd7);
`else
        check("t5_nobypass_ready", rob_rs2_ready, 32'd0);
        check("t5_nobypass_value", rob_rs2_value, 32'd0);
`endif
        step();
        cdb_valid = 1'b0; cdb_tag = 5'd0; cdb_value = 32'd0;
        #1;
        check("t5_later_ready", rob_rs2_ready, 32'd1);
        check("t5_later_value", rob_rs2_value, 32'd7);
        rs2_id = 5'd0;
        #1;
        check("t5_tag0_ready", rob_rs2_ready, 32'd0);

        // 6: stall freezes, async rst wins
        do_reset();
        issue(5'd8, 1'b0, 1'b0);
        cdb(5'd1, 32'h9, 1'b0, 32'd0);
        rdy = 1'b0;
        run_add = 1'b1; rd = 5'd4; rd_hv = 1'b1;
        #1;
        check("t6_stall_upd", run_upd, 32'd0);
        step();
        run_add = 1'b0;
        check("t6_tail_frozen", tail, 32'd2);
        check("t6_head_frozen", head, 32'd1);
        rdy = 1'b1;
        #1;
        check("t6_resume_upd", run_upd, 32'd1);
        check("t6_resume_res", res, 32'h9);
        rst = 1'b1;
        #1;
        check("t6_rst_upd", run_upd, 32'd0);
        check("t6_rst_tail", tail, 32'd1);
        check("t6_rst_res", res, 32'd0);
        check("t6_rst_rd", commit_rd, 32'd0);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
